mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WORD_W, default 16: address and data width in bits.
REQ-002 Parameter MEM_LATENCY, default 2, legal range 1..7: cycles a memory access is held on the port.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. Ports are listed below, clock and reset first.
- clk  in  1  : clock; all state changes on the rising edge
- reset  in  1  : synchronous active-high reset
- i_req  in  1  : instruction-fetch request; held high until i_ready
- i_addr  in  WORD_W  : fetch address
- i_ready  out  1  : one-cycle pulse; fetch complete, i_rdata valid
- i_rdata  out  WORD_W  : fetched word
- d_req  in  1  : data request; held high until d_ready
- d_we  in  1  : 1 means store, 0 means load
- d_addr  in  WORD_W  : data address
- d_wdata  in  WORD_W  : store data
- d_ready  out  1  : one-cycle pulse; access complete, d_rdata valid for a load
- d_rdata  out  WORD_W  : loaded word
- mem_read  out  1  : memory read strobe
- mem_write  out  1  : memory write strobe
- mem_addr  out  WORD_W  : memory address
- mem_wdata  out  WORD_W  : memory write data
- mem_rdata  in  WORD_W  : memory read data; valid in the last busy cycle
- busy  out  1  : a transfer is in progress

Function
REQ-004 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-005 Arbitration SHALL happen only in IDLE. If any request is high, the block grants one requester and latches its owner, address, we and wdata. The next state is BUSY with the counter loaded to MEM_LATENCY-1.
REQ-006 In BUSY, the block SHALL drive the latched values onto mem_addr and mem_wdata. It drives mem_read = !we and mem_write = we, and holds them stable in every BUSY cycle. Outside BUSY, all mem_* outputs are 0.
REQ-007 BUSY SHALL last exactly MEM_LATENCY cycles. The counter decrements each cycle. At counter 0, a load captures mem_rdata into the owner's rdata register, and the next state is DONE.
REQ-008 DONE SHALL last one cycle. The owner's ready output is 1 in DONE and 0 in every other state. The next state is IDLE.
REQ-009 Latency from the grant edge to ready SHALL be MEM_LATENCY+1 cycles. The minimum request-to-request turnaround is MEM_LATENCY+2 cycles.
REQ-010 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-011 If req drops during BUSY, the transfer SHALL complete and ready SHALL still pulse. No abort.
REQ-012 Changes on input address or data after the grant SHALL be ignored until the next grant.
REQ-013 i_rdata and d_rdata SHALL hold their last captured value until the next load for the same owner completes. A store SHALL not modify d_rdata.
REQ-014 If both requests are high in IDLE, the winner SHALL be chosen per REQ-018.
REQ-015 busy SHALL be 1 in BUSY and DONE, and 0 in IDLE.
REQ-016 d_we together with i_req is irrelevant: an instruction grant SHALL always be a read.

Reset
REQ-017 When reset is high at a clock edge, the block SHALL enter IDLE. The counter, i_ready, d_ready, mem_read, mem_write and busy go to 0, i_rdata and d_rdata go to 0, and the round-robin pointer is set to favour the data port. A transfer in progress is dropped without a ready pulse, and mem strobes are 0 in the cycle after the reset edge.

Configuration
REQ-018 ARB_ROUND_ROBIN_EN selects the arbitration policy.
- Defined: on a conflict, the port not granted last wins. A one-bit last-owner pointer is updated on each grant.
- Undefined: fixed priority, the data port always wins, and no pointer register exists.

Structure
REQ-019 The shared package SHALL hold the FSM state encoding (IDLE, BUSY, DONE), the owner encoding (OWN_I, OWN_D) and the default word width.
REQ-020 One sub-module SHALL be used: arb_pick, a combinational two-way arbiter taking the requests and pointer and returning the grant. All other logic is inline.

Verification
REQ-021 Single load: d_req=1, d_we=0, d_addr=0x0010, memory[0x0010]=0xBEEF, latency 2. Required: mem_read high for exactly 2 cycles, then d_ready pulses with d_rdata=0xBEEF, 3 cycles after the grant edge.
REQ-022 Store: d_we=1, d_addr=0x0020, d_wdata=0x1234. Required: mem_write high for 2 cycles with those values, d_ready pulses once, d_rdata unchanged.
REQ-023 Conflict: i_req and d_req rise in the same cycle, both held high. Without the macro: D, I, D, I is not the order; the order is D, D, D... until d_req drops. With the macro: grants alternate D, I, D, I.
REQ-024 Input churn: d_addr is changed from 0x0030 to 0x0040 one cycle after the grant. Required: mem_addr stays 0x0030 throughout the transfer.
REQ-025 Reset mid-transfer: reset is asserted in the first BUSY cycle. Required: next cycle is IDLE, mem_read=0, busy=0, and no ready pulse occurs.
REQ-026 Early drop: i_req is deasserted in the first BUSY cycle. Required: the transfer completes and i_ready pulses once.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state/owner encodings and default width
package mem_port_arbiter_pkg;
    localparam int WORD_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: combinational two-way arbiter, grant=1 selects the data port
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last,
    output logic valid,
    output logic grant
);
    // on a conflict the port that did not win last time is granted
    always_comb begin
        valid = i_req | d_req;
        grant = (i_req && d_req) ? (last != OWN_D) : d_req;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters
// ARB_ROUND_ROBIN_EN: defined gives round-robin on conflicts, else data port always wins
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int MEM_LATENCY = 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [WORD_W-1:0] i_addr,
    output logic              i_ready,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy
);
    state_t            state, nxt;
    owner_t            owner, gnt;
    logic [2:0]        cnt;
    logic              we, valid, gnt_bit, last;
    logic [WORD_W-1:0] addr, wdata;

    assign gnt = owner_t'(gnt_bit);

    arb_pick u_pick (
        .i_req (i_req),
        .d_req (d_req),
        .last  (last),
        .valid (valid),
        .grant (gnt_bit)
    );

`ifdef ARB_ROUND_ROBIN_EN
    // last-owner pointer, reset so the data port wins the first conflict
    always_ff @(posedge clk) begin
        if (reset)
            last <= 1'b0;
        else if (state == IDLE && valid)
            last <= gnt_bit;
    end
`else
    // fixed priority: pretend the fetch port always won last time
    assign last = 1'b0;
`endif

    // state register, request latch, latency counter and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            owner   <= OWN_D;
            we      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && valid) begin
                owner <= gnt;
                we    <= (gnt == OWN_D) && d_we;
                addr  <= (gnt == OWN_D) ? d_addr : i_addr;
                wdata <= d_wdata;
                cnt   <= 3'(MEM_LATENCY - 1);
            end
            if (state == BUSY) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd0 && !we) begin
                    if (owner == OWN_D)
                        d_rdata <= mem_rdata;
                    else
                        i_rdata <= mem_rdata;
                end
            end
        end
    end

    // next state and all port outputs decoded from the current state
    always_comb begin
        nxt       = state;
        busy      = state != IDLE;
        mem_read  = (state == BUSY) && !we;
        mem_write = (state == BUSY) && we;
        mem_addr  = (state == BUSY) ? addr : '0;
        mem_wdata = (state == BUSY) ? wdata : '0;
        i_ready   = (state == DONE) && (owner == OWN_I);
        d_ready   = (state == DONE) && (owner == OWN_D);
        nxt       = (state == IDLE) ? (valid ? BUSY : IDLE)
                  : (state == BUSY) ? ((cnt == 3'd0) ? DONE : BUSY)
                  : IDLE;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with a fixed memory image
module tb_mem_port_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_ready, d_ready, mem_read, mem_write, busy;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    int          n_checks = 0, n_fail = 0;
    int          lat, nrd, nwr;
    logic [15:0] a0, w0;
    logic        stable, rdy_i, rdy_d, seen;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (mem_addr)
            16'h0010: mem_rdata = 16'hBEEF;
            16'h0050: mem_rdata = 16'hCAFE;
            16'h0060: mem_rdata = 16'h7777;
            16'h0070: mem_rdata = 16'hD000;
            16'h0080: mem_rdata = 16'h1000;
            default:  mem_rdata = 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic watch(input logic churn, input logic drop, output int lt, output int rd,
                         output int wr, output logic [15:0] a, output logic [15:0] w,
                         output logic st, output logic ri, output logic rdd);
        lt = 0; rd = 0; wr = 0; a = '0; w = '0; st = 1'b1; ri = 1'b0; rdd = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_read) rd++;
            if (mem_write) wr++;
            if (mem_read || mem_write) begin
                if (rd + wr == 1) begin
                    a = mem_addr;
                    w = mem_wdata;
                end else if (mem_addr !== a || mem_wdata !== w) st = 1'b0;
            end
            if (k == 1 && churn) d_addr = 16'h0040;
            if (k == 1 && drop) i_req = 1'b0;
            if (i_ready || d_ready) begin
                lt = k; ri = i_ready; rdd = d_ready;
                break;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_strobes", {mem_read, mem_write}, 0);
        check("rst_ready", {i_ready, d_ready}, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        reset = 1'b0;

        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        watch(0, 0, lat, nrd, nwr, a0, w0, stable, rdy_i, rdy_d);
        d_req = 1'b0;
        check("load_lat", lat, 3);
        check("load_nrd", nrd, 2);
        check("load_nwr", nwr, 0);
        check("load_addr", a0, 16'h0010);
        check("load_rdy", {rdy_i, rdy_d}, 2'b01);
        check("load_rdata", d_rdata, 16'hBEEF);
        @(negedge clk);
        check("load_pulse", {i_ready, d_ready, busy, mem_read}, 0);

        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        watch(0, 0, lat, nrd, nwr, a0, w0, stable, rdy_i, rdy_d);
        d_req = 1'b0; d_we = 1'b0;
        check("store_nwr", nwr, 2);
        check("store_nrd", nrd, 0);
        check("store_addr", a0, 16'h0020);
        check("store_wdata", w0, 16'h1234);
        check("store_stable", stable, 1);
        check("store_rdy", {rdy_i, rdy_d}, 2'b01);
        check("store_rdata", d_rdata, 16'hBEEF);
        @(negedge clk);
        check("store_pulse", {i_ready, d_ready, mem_write}, 0);

        i_req = 1'b1; i_addr = 16'h0050; d_we = 1'b1;
        watch(0, 0, lat, nrd, nwr, a0, w0, stable, rdy_i, rdy_d);
        i_req = 1'b0; d_we = 1'b0;
        check("fetch_lat", lat, 3);
        check("fetch_strobes", {nrd[7:0], nwr[7:0]}, {8'd2, 8'd0});
        check("fetch_rdy", {rdy_i, rdy_d}, 2'b10);
        check("fetch_rdata", i_rdata, 16'hCAFE);
        check("fetch_drdata", d_rdata, 16'hBEEF);
        @(negedge clk);

        d_req = 1'b1; d_addr = 16'h0030;
        watch(1, 0, lat, nrd, nwr, a0, w0, stable, rdy_i, rdy_d);
        d_req = 1'b0;
        check("churn_addr", a0, 16'h0030);
        check("churn_stable", stable, 1);
        check("churn_rdy", {rdy_i, rdy_d}, 2'b01);
        check("churn_rdata", d_rdata, 16'h0000);
        @(negedge clk);

        i_req = 1'b1; i_addr = 16'h0060;
        watch(0, 1, lat, nrd, nwr, a0, w0, stable, rdy_i, rdy_d);
        check("drop_lat", lat, 3);
        check("drop_rdy", {rdy_i, rdy_d}, 2'b10);
        check("drop_rdata", i_rdata, 16'h7777);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | i_ready | d_ready | busy;
        end
        check("drop_once", seen, 0);

        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
        @(negedge clk);
        check("rstmid_busy_rd", {busy, mem_read}, 2'b11);
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check("rstmid_idle", {busy, mem_read, mem_write}, 0);
        check("rstmid_rdata", {i_rdata, d_rdata}, 0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | i_ready | d_ready;
        end
        check("rstmid_noready", seen, 0);

        i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0080; d_addr = 16'h0070;
        for (int g = 0; g < 4; g++) begin
            watch(0, 0, lat, nrd, nwr, a0, w0, stable, rdy_i, rdy_d);
            check($sformatf("conf_grant%0d", g), {rdy_i, rdy_d},
                  (RR && (g % 2 == 1)) ? 2'b10 : 2'b01);
        end
        check("conf_drdata", d_rdata, 16'hD000);
        d_req = 1'b0;
        watch(0, 0, lat, nrd, nwr, a0, w0, stable, rdy_i, rdy_d);
        i_req = 1'b0;
        check("conf_after", {rdy_i, rdy_d}, 2'b10);
        check("conf_irdata", i_rdata, 16'h1000);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
